// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the clock, issues request-to-send,
// shifts one byte plus odd parity on device clock falling edges and checks the device ack.
module ps2_command_tx #(
  parameter int unsigned CLK_INHIBIT_CYCLES = 5050,
  parameter int unsigned START_TIMEOUT      = 750000,
  parameter int unsigned XFER_TIMEOUT       = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] the_command,
  input  logic       send_command,
  input  logic       ps2_clk_posedge,
  input  logic       ps2_clk_negedge,
  input  logic       ps2_data,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       command_was_sent,
  output logic       error_communication_timed_out
);

  localparam int unsigned CntMax =
      (CLK_INHIBIT_CYCLES > START_TIMEOUT) ?
      ((CLK_INHIBIT_CYCLES > XFER_TIMEOUT) ? CLK_INHIBIT_CYCLES : XFER_TIMEOUT) :
      ((START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT);
  localparam int unsigned CntW = $clog2(CntMax + 1);

  // The RTS cycle keeps the clock low too, so INHIBIT itself lasts one cycle less.
  localparam logic [CntW-1:0] InhibitLast = CntW'(CLK_INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] StartLimit  = CntW'(START_TIMEOUT);
  localparam logic [CntW-1:0] XferLimit   = CntW'(XFER_TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StWaitClk,
    StTxBits,
    StWaitAck,
    StDone,
    StError
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            clk_low_q, clk_low_d;
  logic            dat_low_q, dat_low_d;
  logic            parity;
  logic            unused_posedge;

  // Only falling edges move data; rising edges belong to the device.
  assign unused_posedge = ps2_clk_posedge;

  assign parity  = ~^data_q;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CntW'(1);

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_inc;
    dat_low_d = dat_low_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (send_command) begin
          data_d  = the_command;
          state_d = StInhibit;
        end
      end

      StInhibit: begin
        if (cnt_inc >= InhibitLast) begin
          cnt_d     = '0;
          dat_low_d = 1'b1;
          state_d   = StRts;
        end
      end

      StRts: begin
        state_d = StWaitClk;
      end

      StWaitClk: begin
        if (ps2_clk_negedge) begin
          dat_low_d = ~data_q[0];
          bit_idx_d = 4'd1;
          cnt_d     = CntW'(1);
          state_d   = StTxBits;
        end else if (cnt_inc >= StartLimit) begin
          state_d = StError;
        end
      end

      StTxBits: begin
        if (ps2_clk_negedge) begin
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd9) begin
            dat_low_d = 1'b0;
            state_d   = StWaitAck;
          end else if (bit_idx_q == 4'd8) begin
            dat_low_d = ~parity;
          end else begin
            dat_low_d = ~data_q[bit_idx_q[2:0]];
          end
        end else if (cnt_inc >= XferLimit) begin
          state_d = StError;
        end
      end

      StWaitAck: begin
        if (ps2_clk_negedge) begin
          state_d = ps2_data ? StError : StDone;
        end else if (cnt_inc >= XferLimit) begin
          state_d = StError;
        end
      end

      StDone, StError: begin
        cnt_d = '0;
        if (!send_command) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    if (state_d inside {StIdle, StInhibit, StDone, StError}) dat_low_d = 1'b0;
    clk_low_d = (state_d == StInhibit) || (state_d == StRts);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= StIdle;
      data_q    <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      clk_low_q <= 1'b0;
      dat_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      clk_low_q <= clk_low_d;
      dat_low_q <= dat_low_d;
    end
  end

  assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;

  assign command_was_sent              = (state_q == StDone);
  assign error_communication_timed_out = (state_q == StError);

endmodule

// File: tb/tb_ps2_command_tx.sv
// Bench for ps2_command_tx: a device model clocks frames, a scoreboard holds expected
// line bits and outcomes, timeouts are scaled down through the parameters.
module tb_ps2_command_tx;

  localparam int unsigned Inh     = 40;
  localparam int unsigned StartTo = 300;
  localparam int unsigned XferTo  = 600;
  localparam int unsigned Hp      = 10;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] the_command;
  logic       send_command;
  logic       ps2_clk_posedge;
  logic       ps2_clk_negedge;
  logic       ps2_data = 1'b1;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic       dev_dat_low;
  wire        ps2_clk_w;
  wire        ps2_dat_w;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int res_q[$];

  pullup (ps2_clk_w);
  pullup (ps2_dat_w);
  assign ps2_dat_w = dev_dat_low ? 1'b0 : 1'bz;

  always #10 CLOCK_50 = ~CLOCK_50;

  // Receive-path stand-in: registered copy of the data line.
  always @(posedge CLOCK_50) begin
    cyc      <= cyc + 1;
    ps2_data <= ps2_dat_w;
  end

  ps2_command_tx #(
    .CLK_INHIBIT_CYCLES(Inh),
    .START_TIMEOUT     (StartTo),
    .XFER_TIMEOUT      (XferTo)
  ) dut (
    .CLOCK_50                     (CLOCK_50),
    .reset                        (reset),
    .the_command                  (the_command),
    .send_command                 (send_command),
    .ps2_clk_posedge              (ps2_clk_posedge),
    .ps2_clk_negedge              (ps2_clk_negedge),
    .ps2_data                     (ps2_data),
    .PS2_CLK                      (ps2_clk_w),
    .PS2_DAT                      (ps2_dat_w),
    .command_was_sent             (command_was_sent),
    .error_communication_timed_out(error_communication_timed_out)
  );

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  task automatic wait_result(input int bound, output int at);
    at = -1;
    for (int k = 0; k < bound; k++) begin
      if (command_was_sent || error_communication_timed_out) begin
        at = cyc;
        break;
      end
      tick();
    end
  endtask

  // Outcome codes: 0 none (reset), 1 sent, 2 error.
  task automatic send_frame(input logic [7:0] cmd, input int n_clk, input bit ack,
                            input int drop_at, input int reset_at);
    int         n, low, rts_cyc, neg_cyc, at, e;
    logic [10:0] bits;
    bits = {1'b1, ~^cmd, cmd, 1'b0};
    for (int i = 0; i < 11; i++) exp_q.push_back(int'(bits[i]));
    if (reset_at < n_clk) res_q.push_back(0);
    else if (n_clk < 11 || !ack) res_q.push_back(2);
    else res_q.push_back(1);

    the_command  = cmd;
    send_command = 1'b1;
    n = 0;
    while (ps2_clk_w !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    low     = 0;
    rts_cyc = -1;
    while (ps2_clk_w === 1'b0 && low < int'(Inh) + 10) begin
      if (rts_cyc < 0 && ps2_dat_w === 1'b0) rts_cyc = cyc;
      low++;
      tick();
      if (low == 2) the_command = ~cmd;
    end
    check("inhibit_len", low, Inh);
    check("rts_seen", int'(rts_cyc >= 0), 1);
    e = exp_q.pop_front();
    check("start_bit", ps2_dat_w, e);

    if (n_clk == 0) begin
      wait_result(StartTo + 20, at);
      e = res_q.pop_front();
      check("start_timeout_at", at - rts_cyc, StartTo);
      check("start_timeout_err", error_communication_timed_out, int'(e == 2));
      check("start_timeout_sent", command_was_sent, 0);
      check("start_timeout_dat", ps2_dat_w, 1);
      send_command = 1'b0;
      tick();
      check("err_clear", error_communication_timed_out, 0);
      exp_q.delete();
      return;
    end

    neg_cyc = cyc;
    for (int i = 0; i < n_clk; i++) begin
      if (i == 10) begin
        dev_dat_low = ack;
        repeat (3) tick();
      end
      if (i == drop_at) send_command = 1'b0;
      if (i == 0) neg_cyc = cyc;
      ps2_clk_negedge = 1'b1;
      tick();
      ps2_clk_negedge = 1'b0;
      if (i == 10) begin
        e = res_q.pop_front();
        check("result_sent", command_was_sent, int'(e == 1));
        check("result_err", error_communication_timed_out, int'(e == 2));
        check("result_clk", ps2_clk_w, 1);
        dev_dat_low = 1'b0;
        if (drop_at < 11) begin
          tick();
          check("drop_clear", command_was_sent | error_communication_timed_out, 0);
        end else begin
          repeat (4) tick();
          check("result_hold", command_was_sent | error_communication_timed_out, 1);
          check("result_excl", command_was_sent & error_communication_timed_out, 0);
          send_command = 1'b0;
          tick();
          check("result_clear", command_was_sent | error_communication_timed_out, 0);
        end
      end else begin
        repeat (Hp - 1) tick();
        e = exp_q.pop_front();
        check($sformatf("bit%0d", i), ps2_dat_w, e);
        if (i == reset_at) begin
          reset        = 1'b1;
          send_command = 1'b0;
          tick();
          reset = 1'b0;
          e = res_q.pop_front();
          check("rst_mid_clk", ps2_clk_w, 1);
          check("rst_mid_dat", ps2_dat_w, 1);
          check("rst_mid_out", command_was_sent | error_communication_timed_out, e);
          exp_q.delete();
          return;
        end
        ps2_clk_posedge = 1'b1;
        tick();
        ps2_clk_posedge = 1'b0;
        repeat (Hp - 1) tick();
      end
    end

    if (n_clk < 11) begin
      wait_result(XferTo + 50, at);
      e = res_q.pop_front();
      check("xfer_timeout_at", at - neg_cyc, XferTo);
      check("xfer_timeout_err", error_communication_timed_out, int'(e == 2));
      check("xfer_timeout_sent", command_was_sent, 0);
      send_command = 1'b0;
      tick();
      check("err_clear", error_communication_timed_out, 0);
    end
    exp_q.delete();
  endtask

  initial begin
    reset           = 1'b1;
    send_command    = 1'b0;
    the_command     = 8'h00;
    ps2_clk_posedge = 1'b0;
    ps2_clk_negedge = 1'b0;
    dev_dat_low     = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_clk", ps2_clk_w, 1);
    check("rst_dat", ps2_dat_w, 1);
    check("rst_sent", command_was_sent, 0);
    check("rst_err", error_communication_timed_out, 0);

    send_frame(8'hF4, 11, 1'b1, 99, 99);
    repeat (3) tick();
    send_frame(8'hED, 11, 1'b1, 99, 99);
    repeat (3) tick();
    send_frame(8'hF4, 11, 1'b1, 99, 1);
    repeat (3) tick();
    send_frame(8'hA5, 0, 1'b1, 99, 99);
    repeat (3) tick();
    send_frame(8'h3C, 4, 1'b1, 99, 99);
    repeat (3) tick();
    send_frame(8'h55, 11, 1'b0, 99, 99);
    repeat (3) tick();
    send_frame(8'hF4, 11, 1'b1, 4, 99);
    repeat (5) tick();
    check("idle_after_drop", ps2_clk_w, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
